note_seq_ctrl: RTL

Parametrised record/playback controller for the note sequencer. It records up to DEPTH notes into an external note memory, one write per load_n press/release. On request it plays them back in order, advancing one step per tick from an internal restartable tick generator. Sits between the board key/switch inputs and the note RAM / tone generator datapath.

---
 rtl/note_seq_pkg.sv | 16 +
 rtl/note_seq_ctrl_if.sv | 31 +++
 rtl/note_tick_gen.sv | 25 ++
 rtl/note_seq_ctrl.sv | 122 ++++++++++++
 4 files changed

// File: rtl/note_seq_pkg.sv
// note_seq_pkg: shared state encoding and default sizing for the note sequencer.
package note_seq_pkg;

  // Controller states, 2-bit encoded
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_PLAY = 2'd2
  } state_t;

  localparam int DEF_DEPTH    = 16;
  localparam int DEF_ADDR_W   = 4;
  localparam int DEF_TICK_DIV = 25000000;  // 0.5 s per step at 50 MHz
  localparam int DEF_TICK_W   = 25;

endpackage

// File: rtl/note_seq_ctrl_if.sv
// note_seq_ctrl_if: key/switch requests in, note memory and playback controls out.
interface note_seq_ctrl_if #(
  parameter int ADDR_W = 4
);
  logic              load_n;
  logic              playback_n;
  logic              stop_n;
  logic              clear;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic              ld_note;
  logic              ld_play;
  logic              note_tick;
  logic [ADDR_W:0]   notes_recorded;
  logic              full;

  // Board side: drives requests, observes controller outputs
  modport master (
    output load_n, playback_n, stop_n, clear,
    input  wr_en, wr_addr, rd_addr, ld_note, ld_play, note_tick,
           notes_recorded, full
  );

  // Controller side
  modport slave (
    input  load_n, playback_n, stop_n, clear,
    output wr_en, wr_addr, rd_addr, ld_note, ld_play, note_tick,
           notes_recorded, full
  );
endinterface

// File: rtl/note_tick_gen.sv
// note_tick_gen: restartable down-counter producing one pulse every TICK_DIV cycles.
module note_tick_gen #(
  parameter int TICK_DIV = 25000000,
  parameter int TICK_W   = 25
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam logic [TICK_W-1:0] RELOAD = TICK_W'(TICK_DIV - 1);

  logic [TICK_W-1:0] cnt;

  assign tick = (cnt == '0);

  // Count down, reload on terminal count or on restart so a new step gets a full period
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                cnt <= RELOAD;
    else if (restart || tick) cnt <= RELOAD;
    else                      cnt <= cnt - 1'b1;
  end

endmodule

// File: rtl/note_seq_ctrl.sv
// note_seq_ctrl: record/playback controller for the note sequencer.
// Build option: define LOOP_PLAYBACK_EN to make playback wrap to the first
// note forever (only stop_n or reset leaves PLAY).
module note_seq_ctrl
  import note_seq_pkg::*;
#(
  parameter int DEPTH    = DEF_DEPTH,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int TICK_DIV = DEF_TICK_DIV,
  parameter int TICK_W   = DEF_TICK_W
) (
  input  logic           clk,
  input  logic           reset,
  note_seq_ctrl_if.slave bus
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  state_t            state, state_nxt;
  logic [ADDR_W:0]   cnt_q;
  logic [ADDR_W-1:0] rd_q;
  logic              full, tick, last_step, restart;
  logic              cnt_clr, cnt_inc, rd_clr, rd_inc;
  logic              wr_en, ld_note, ld_play;

  assign full      = (cnt_q == DEPTH_C);
  assign last_step = ({1'b0, rd_q} == (cnt_q - 1'b1));

  note_tick_gen #(
    .TICK_DIV (TICK_DIV),
    .TICK_W   (TICK_W)
  ) u_tick (
    .clk     (clk),
    .reset   (reset),
    .restart (restart),
    .tick    (tick)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next state, strobes and datapath controls
  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    rd_clr    = 1'b0;
    rd_inc    = 1'b0;
    restart   = 1'b0;
    wr_en     = 1'b0;
    ld_note   = 1'b0;
    ld_play   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (bus.clear) begin
          cnt_clr = 1'b1;
        end else if (!bus.load_n && !full) begin
          state_nxt = S_LOAD;
        end else if (!bus.playback_n && (cnt_q != '0)) begin
          state_nxt = S_PLAY;
          rd_clr    = 1'b1;
          restart   = 1'b1;
        end
      end
      S_LOAD: begin
        ld_note = 1'b1;
        // Commit on release; the write lands at the pre-increment count
        if (bus.load_n) begin
          wr_en     = 1'b1;
          cnt_inc   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_PLAY: begin
        ld_play = 1'b1;
        // Stop wins over a same-cycle step
        if (!bus.stop_n) begin
          state_nxt = S_IDLE;
          rd_clr    = 1'b1;
        end else if (tick) begin
          if (last_step) begin
`ifdef LOOP_PLAYBACK_EN
            rd_clr    = 1'b1;
`else
            rd_clr    = 1'b1;
            state_nxt = S_IDLE;
`endif
          end else begin
            rd_inc = 1'b1;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Recorded-note count and playback pointer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      rd_q  <= '0;
    end else begin
      if (cnt_clr)      cnt_q <= '0;
      else if (cnt_inc) cnt_q <= cnt_q + 1'b1;
      if (rd_clr)       rd_q  <= '0;
      else if (rd_inc)  rd_q  <= rd_q + 1'b1;
    end
  end

  assign bus.wr_en          = wr_en;
  assign bus.wr_addr        = cnt_q[ADDR_W-1:0];
  assign bus.rd_addr        = rd_q;
  assign bus.ld_note        = ld_note;
  assign bus.ld_play        = ld_play;
  assign bus.note_tick      = tick;
  assign bus.notes_recorded = cnt_q;
  assign bus.full           = full;

endmodule
